max_unpool_upsampler: RTL and testbench



---
 rtl/max_unpool_upsampler_if.sv | 24 ++
 rtl/max_unpool_upsampler.sv | 134 +++++++++++++
 tb/tb_max_unpool_upsampler.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/max_unpool_upsampler_if.sv
// Pixel stream bundle between the max-unpool upsampler and its neighbours.
`timescale 1ns/1ps
interface max_unpool_upsampler_if #(
  parameter int unsigned DATA_W = 22
) ();
  logic                     start_signal;
  logic                     pixel_valid;
  logic                     pixel_ready;
  logic signed [DATA_W-1:0] pixel_in;
  logic signed [DATA_W-1:0] result_out;
  logic                     result_valid;
  logic                     result_eol;
  logic                     done_signal;

  modport master (
    output start_signal, pixel_valid, pixel_in,
    input  pixel_ready, result_out, result_valid, result_eol, done_signal
  );

  modport slave (
    input  start_signal, pixel_valid, pixel_in,
    output pixel_ready, result_out, result_valid, result_eol, done_signal
  );
endinterface

// File: rtl/max_unpool_upsampler.sv
// 2x nearest-neighbour upsampler: each pooled pixel becomes a 2x2 block,
// even output rows stream from the input, odd rows replay a line buffer.
`timescale 1ns/1ps
module max_unpool_upsampler #(
  parameter int unsigned IN_WIDTH  = 16,
  parameter int unsigned IN_HEIGHT = 16,
  parameter int unsigned DATA_W    = 22
) (
  input  logic                    clk,
  input  logic                    rst,
  max_unpool_upsampler_if.slave   bus
);
  localparam int unsigned XW = $clog2(IN_WIDTH) + 1;
  localparam int unsigned YW = $clog2(IN_HEIGHT) + 1;
  localparam int unsigned AW = (IN_WIDTH > 1) ? $clog2(IN_WIDTH) : 1;
  localparam logic [XW-1:0] X_LAST = XW'(IN_WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(IN_HEIGHT - 1);

  typedef enum logic [1:0] {IDLE, EVEN_ROW, ODD_ROW, DONE} state_t;

  state_t                   state, state_d;
  logic [XW-1:0]            in_x, in_x_d;
  logic [YW-1:0]            in_y, in_y_d;
  logic                     phase, phase_d;
  logic signed [DATA_W-1:0] out_q, out_d;
  logic                     valid_q, valid_d;
  logic                     eol_q, eol_d;
  logic                     buf_we;
  logic                     ready;
  logic                     accept;
  logic signed [DATA_W-1:0] line_buf [IN_WIDTH];

  assign ready  = (state == EVEN_ROW) && !phase;
  assign accept = ready && bus.pixel_valid;

  assign bus.pixel_ready  = ready;
  assign bus.result_out   = out_q;
  assign bus.result_valid = valid_q;
  assign bus.result_eol   = eol_q;
  assign bus.done_signal  = (state == DONE);

  // State, counters and registered output beat
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      in_x    <= '0;
      in_y    <= '0;
      phase   <= 1'b0;
      out_q   <= '0;
      valid_q <= 1'b0;
      eol_q   <= 1'b0;
    end else begin
      state   <= state_d;
      in_x    <= in_x_d;
      in_y    <= in_y_d;
      phase   <= phase_d;
      out_q   <= out_d;
      valid_q <= valid_d;
      eol_q   <= eol_d;
    end
  end

  // Even-row pixels are kept for replay on the following odd row
  always_ff @(posedge clk) begin
    if (buf_we) line_buf[in_x[AW-1:0]] <= bus.pixel_in;
  end

  always_comb begin
    state_d = state;
    in_x_d  = in_x;
    in_y_d  = in_y;
    phase_d = phase;
    out_d   = out_q;
    valid_d = 1'b0;
    eol_d   = 1'b0;
    buf_we  = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start_signal) begin
          state_d = EVEN_ROW;
          in_x_d  = '0;
          in_y_d  = '0;
          phase_d = 1'b0;
        end
      end
      EVEN_ROW: begin
        if (!phase) begin
          if (accept) begin
            out_d   = bus.pixel_in;
            valid_d = 1'b1;
            buf_we  = 1'b1;
            phase_d = 1'b1;
          end
        end else begin
          // Second beat of the pair is never stalled
          valid_d = 1'b1;
          phase_d = 1'b0;
          if (in_x == X_LAST) begin
            eol_d   = 1'b1;
            in_x_d  = '0;
            state_d = ODD_ROW;
          end else begin
            in_x_d = in_x + XW'(1);
          end
        end
      end
      ODD_ROW: begin
        out_d   = line_buf[in_x[AW-1:0]];
        valid_d = 1'b1;
        phase_d = !phase;
        if (phase) begin
          if (in_x == X_LAST) begin
            eol_d  = 1'b1;
            in_x_d = '0;
            if (in_y == Y_LAST) begin
              state_d = DONE;
            end else begin
              in_y_d  = in_y + YW'(1);
              state_d = EVEN_ROW;
            end
          end else begin
            in_x_d = in_x + XW'(1);
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end
endmodule

// File: tb/tb_max_unpool_upsampler.sv
// Scoreboard bench for max_unpool_upsampler: a 16x16 and a 2x1 instance.
`timescale 1ns/1ps
module tb_max_unpool_upsampler;
  localparam int unsigned DW = 22;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          eol;
    logic          done;
    logic          rdy;
  } item_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  max_unpool_upsampler_if #(.DATA_W(DW)) bb ();
  max_unpool_upsampler_if #(.DATA_W(DW)) sb ();

  max_unpool_upsampler #(.IN_WIDTH(16), .IN_HEIGHT(16), .DATA_W(DW)) dut_big (
    .clk(clk), .rst(rst), .bus(bb.slave));
  max_unpool_upsampler #(.IN_WIDTH(2), .IN_HEIGHT(1), .DATA_W(DW)) dut_small (
    .clk(clk), .rst(rst), .bus(sb.slave));

  item_t q_big[$];
  item_t q_small[$];
  int    checks = 0;
  int    failures = 0;
  int    beats[2], eols[2], dones[2], gaps[2];
  bit    active[2];

  function automatic logic [DW-1:0] pixval(input int kind, input int x, input int y);
    case (kind)
      0:       return DW'(y * 16 + x);
      1:       return DW'(-(y * 16 + x) - 1);
      default: return (x == 0) ? DW'(-5) : DW'(7);
    endcase
  endfunction

  task automatic push_item(input int id, input item_t it);
    if (id == 0) q_big.push_back(it);
    else         q_small.push_back(it);
  endtask

  // Expected beats of one full frame, including expected pixel_ready after each beat
  task automatic push_frame(input int id, input int w, input int h, input int kind);
    for (int y = 0; y < h; y++) begin
      for (int x = 0; x < w; x++) begin
        push_item(id, '{pixval(kind, x, y), 1'b0, 1'b0, 1'b0});
        push_item(id, '{pixval(kind, x, y), x == w - 1, 1'b0, x != w - 1});
      end
      for (int ox = 0; ox < 2 * w; ox++) begin
        push_item(id, '{pixval(kind, ox / 2, y), ox == 2 * w - 1,
                        (ox == 2 * w - 1) && (y == h - 1),
                        (ox == 2 * w - 1) && (y != h - 1)});
      end
    end
  endtask

  task automatic observe(input int id, input logic v, input logic [DW-1:0] d,
                         input logic e, input logic dn, input logic r);
    item_t exp;
    checks++;
    if (dn && !v) begin
      failures++;
      $display("FAIL done_without_valid dut%0d t=%0t got done=1 valid=0 expected valid=1", id, $time);
    end
    if (v) begin
      checks++;
      if ((id == 0 && q_big.size() == 0) || (id == 1 && q_small.size() == 0)) begin
        failures++;
        $display("FAIL unexpected_beat dut%0d t=%0t got data=%h expected no beat", id, $time, d);
      end else begin
        exp = (id == 0) ? q_big.pop_front() : q_small.pop_front();
        if (d !== exp.data || e !== exp.eol || dn !== exp.done || r !== exp.rdy) begin
          failures++;
          $display("FAIL beat dut%0d #%0d got data=%h eol=%b done=%b rdy=%b expected data=%h eol=%b done=%b rdy=%b",
                   id, beats[id], d, e, dn, r, exp.data, exp.eol, exp.done, exp.rdy);
        end
      end
      beats[id]++;
      eols[id] += int'(e);
      dones[id] += int'(dn);
      active[id] = !dn;
    end else if (active[id]) begin
      // A bubble is only legal while waiting for the next input pixel
      gaps[id]++;
      checks++;
      if (r !== 1'b1) begin
        failures++;
        $display("FAIL gap_not_at_pair_boundary dut%0d t=%0t got pixel_ready=%b expected 1", id, $time, r);
      end
    end
  endtask

  always @(negedge clk) observe(0, bb.result_valid, bb.result_out, bb.result_eol, bb.done_signal, bb.pixel_ready);
  always @(negedge clk) observe(1, sb.result_valid, sb.result_out, sb.result_eol, sb.done_signal, sb.pixel_ready);

  task automatic drive(input int id, input logic valid, input logic [DW-1:0] v);
    if (id == 0) begin bb.pixel_valid = valid; bb.pixel_in = v; end
    else         begin sb.pixel_valid = valid; sb.pixel_in = v; end
  endtask

  task automatic set_start(input int id, input logic s);
    #1;
    if (id == 0) bb.start_signal = s;
    else         sb.start_signal = s;
  endtask

  function automatic logic get_ready(input int id);
    return (id == 0) ? bb.pixel_ready : sb.pixel_ready;
  endfunction

  task automatic send(input int id, input logic [DW-1:0] v);
    bit   ok = 1'b0;
    logic r;
    #1 drive(id, 1'b1, v);
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk) r = get_ready(id);
      @(posedge clk) ok = r;
    end
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL accept_timeout dut%0d pixel=%h got no accept expected accept", id, v);
    end
  endtask

  task automatic run_frame(input int id, input int w, input int h, input int kind,
                           input bit stall, input bit pulse, input int rows);
    push_frame(id, w, h, kind);
    beats[id] = 0; eols[id] = 0; dones[id] = 0; gaps[id] = 0;
    set_start(id, 1'b1);
    @(posedge clk);
    set_start(id, 1'b0);
    for (int y = 0; y < rows; y++) begin
      for (int x = 0; x < w; x++) begin
        if (pulse && y == 0 && x == 3) set_start(id, 1'b1);
        send(id, pixval(kind, x, y));
        if (pulse && y == 0 && x == 3) set_start(id, 1'b0);
        if (stall && y == 2 && x == 7) begin
          #1 drive(id, 1'b0, '0);
          repeat (4) @(posedge clk);
        end
        if (pulse && y == 0 && x == w - 1) begin
          set_start(id, 1'b1);
          repeat (3) @(posedge clk);
          set_start(id, 1'b0);
        end
      end
    end
    #1 drive(id, 1'b0, '0);
  endtask

  task automatic wait_done(input int id);
    bit seen = 1'b0;
    for (int i = 0; i < 400 && !seen; i++) begin
      @(negedge clk) seen = (id == 0) ? bb.done_signal : sb.done_signal;
    end
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL done_timeout dut%0d got no done_signal expected one", id);
    end
  endtask

  task automatic check_totals(input int id, input int w, input int h, input int exp_gaps);
    checks++;
    if (beats[id] != 4 * w * h || eols[id] != 2 * h || dones[id] != 1 || gaps[id] != exp_gaps) begin
      failures++;
      $display("FAIL frame_totals dut%0d got beats=%0d eols=%0d dones=%0d gaps=%0d expected %0d %0d 1 %0d",
               id, beats[id], eols[id], dones[id], gaps[id], 4 * w * h, 2 * h, exp_gaps);
    end
  endtask

  task automatic check_quiet(input string nm);
    checks++;
    if (bb.result_valid !== 1'b0 || bb.result_out !== '0 || bb.result_eol !== 1'b0 ||
        bb.done_signal !== 1'b0 || bb.pixel_ready !== 1'b0) begin
      failures++;
      $display("FAIL %s got valid=%b out=%h eol=%b done=%b ready=%b expected all 0",
               nm, bb.result_valid, bb.result_out, bb.result_eol, bb.done_signal, bb.pixel_ready);
    end
  endtask

  initial begin
    rst = 1'b1;
    bb.start_signal = 1'b0; sb.start_signal = 1'b0;
    drive(0, 1'b0, '0); drive(1, 1'b0, '0);
    #12 check_quiet("reset_state");
    @(negedge clk) rst = 1'b0;

    // pixel_valid in IDLE is ignored
    drive(0, 1'b1, DW'(99));
    repeat (4) @(negedge clk) check_quiet("idle_ignores_valid");
    drive(0, 1'b0, '0);

    // Continuous 16x16 frame with stray start pulses in even and odd rows
    @(posedge clk);
    run_frame(0, 16, 16, 0, 1'b0, 1'b1, 16);
    wait_done(0);
    @(posedge clk);
    check_totals(0, 16, 16, 0);

    // 2x1 frame with signed values
    run_frame(1, 2, 1, 2, 1'b0, 1'b0, 1);
    wait_done(1);
    @(posedge clk);
    check_totals(1, 2, 1, 0);

    // Three-cycle input stall mid even row
    run_frame(0, 16, 16, 1, 1'b1, 1'b0, 16);
    wait_done(0);
    @(posedge clk);
    check_totals(0, 16, 16, 3);

    // Asynchronous reset during odd row 5
    run_frame(0, 16, 16, 0, 1'b0, 1'b0, 6);
    repeat (6) @(posedge clk);
    #3 rst = 1'b1;
    #1 check_quiet("async_reset_outputs");
    q_big.delete();
    active[0] = 1'b0;
    #20;
    @(negedge clk) rst = 1'b0;
    repeat (5) @(negedge clk) check_quiet("no_output_after_reset");

    // Full frame after reset, then a back-to-back frame
    @(posedge clk);
    run_frame(0, 16, 16, 0, 1'b0, 1'b0, 16);
    wait_done(0);
    @(posedge clk);
    check_totals(0, 16, 16, 0);
    run_frame(0, 16, 16, 1, 1'b0, 1'b0, 16);
    wait_done(0);
    @(posedge clk);
    check_totals(0, 16, 16, 0);

    repeat (3) @(negedge clk);
    checks++;
    if (q_big.size() != 0 || q_small.size() != 0) begin
      failures++;
      $display("FAIL leftover_expected got big=%0d small=%0d expected 0 0", q_big.size(), q_small.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
